stream_arb_mux: RTL and testbench

// - Parametrised successor to the team's combinational 4:1 selector: NCH-input, W-bit stream

---
 rtl/stream_mux_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/stream_arb_mux.sv | 123 ++++++++++++
 tb/tb_stream_arb_mux.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream arbiter/multiplexer.
package stream_mux_pkg;

  // Selection mode: round-robin arbitration or software-fixed channel.
  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mux_mode_t;

  // Smallest channel count the arbiter is meant for.
  localparam int unsigned MIN_NCH = 32'd2;

  // Round-robin pointer value after reset. Pointing at the last channel
  // makes channel 0 the first one searched.
  function automatic int rr_ptr_reset(input int nch);
    return nch - 32'sd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at ptr+1 and wraps
// modulo NCH. The first requesting channel found wins.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  gnt_onehot,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  int   w_cand;
  logic w_hit;

  // Walk the channels in priority order from ptr+1. Only the first hit is taken.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    w_cand     = 32'sd0;
    w_hit      = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      w_cand = int'(ptr) + 32'sd1 + k;
      w_cand = (w_cand >= NCH) ? (w_cand - NCH) : w_cand;
      for (int i = 0; i < NCH; i++) begin
        w_hit         = req[i] & (w_cand == i) & ~gnt_any;
        gnt_onehot[i] = gnt_onehot[i] | w_hit;
        gnt_idx       = w_hit ? SELW'(i) : gnt_idx;
      end
      gnt_any = |gnt_onehot;
    end
  end

endmodule

// File: rtl/stream_arb_mux.sv
// NCH-input stream multiplexer. It has per-channel valid/ready handshakes,
// round-robin or fixed selection, and a single registered output beat.
module stream_arb_mux
  import stream_mux_pkg::*;
#(
  parameter int W    = 8,
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]  in_valid,
  output logic [NCH-1:0]  in_ready,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_ch,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [W-1:0]    r_out_data;
  logic [SELW-1:0] r_out_ch;
  logic            r_out_valid;
  logic [SELW-1:0] r_rr_ptr;

  logic            w_load;
  logic [NCH-1:0]  w_rr_onehot;
  logic [SELW-1:0] w_rr_idx;
  logic            w_rr_any;
  logic [NCH-1:0]  w_fix_onehot;
  logic [NCH-1:0]  w_gnt_onehot;
  logic [SELW-1:0] w_gnt_idx;
  logic            w_gnt_any;
  logic [W-1:0]    w_gnt_data;

  // The register can take a new beat when it is empty or is being drained this cycle.
  assign w_load = ~r_out_valid | out_ready;

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_rr_arbiter (
    .req        (in_valid),
    .ptr        (r_rr_ptr),
    .gnt_onehot (w_rr_onehot),
    .gnt_idx    (w_rr_idx),
    .gnt_any    (w_rr_any)
  );

  // Fixed-select request. A sel value at or above NCH matches no channel,
  // so it never grants.
  always_comb begin
    w_fix_onehot = '0;
    for (int i = 0; i < NCH; i++) begin
      w_fix_onehot[i] = in_valid[i] & (sel == SELW'(i));
    end
  end

  // Pick the grant source according to the mode.
  always_comb begin
    w_gnt_onehot = '0;
    w_gnt_idx    = '0;
    w_gnt_any    = 1'b0;
    case (mux_mode_t'(mode))
      MODE_RR: begin
        w_gnt_onehot = w_rr_onehot;
        w_gnt_idx    = w_rr_idx;
        w_gnt_any    = w_rr_any;
      end
      MODE_FIXED: begin
        w_gnt_onehot = w_fix_onehot;
        w_gnt_idx    = sel;
        w_gnt_any    = |w_fix_onehot;
      end
      default: begin
        w_gnt_onehot = '0;
        w_gnt_idx    = '0;
        w_gnt_any    = 1'b0;
      end
    endcase
  end

  // AND-OR data select driven by the one-hot grant.
  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < NCH; i++) begin
      w_gnt_data = w_gnt_data | (in_data[i*W +: W] & {W{w_gnt_onehot[i]}});
    end
  end

  // in_ready depends combinationally on out_ready. It is forced low while
  // reset is asserted.
  assign in_ready = w_gnt_onehot & {NCH{w_load & rst_n}};

  // Output register and round-robin pointer. On load with no grant, only
  // valid falls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_rr_ptr    <= SELW'(rr_ptr_reset(NCH));
    end else if (w_load) begin
      if (w_gnt_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_gnt_data;
        r_out_ch    <= w_gnt_idx;
        r_rr_ptr    <= w_gnt_idx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Scoreboard bench for stream_arb_mux with W=8 and NCH=4.
module tb_stream_arb_mux;

  localparam int W    = 8;
  localparam int NCH  = 4;
  localparam int SELW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_ready;
  logic             mode;
  logic [SELW-1:0]  sel;
  logic [W-1:0]     out_data;
  logic [SELW-1:0]  out_ch;
  logic             out_valid;
  logic             out_ready;

  int n_checks = 0;
  int n_errors = 0;

  int                  m_ptr = NCH - 1;
  logic [SELW+W-1:0]   sb[$];

  logic [W-1:0]    rr_tbl [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
  logic [SELW-1:0] rr_ch  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [SELW-1:0] sp_ch  [4] = '{2'd3, 2'd1, 2'd3, 2'd1};

  stream_arb_mux #(.W(W), .NCH(NCH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference grant. The result g is -1 when nothing is granted.
  task automatic model_grant(input logic [NCH-1:0] v, input logic m,
                             input logic [SELW-1:0] s, input int ptr, output int g);
    g = -1;
    if (m == 1'b0) begin
      for (int k = 1; k <= NCH; k++) begin
        int idx;
        idx = (ptr + k) % NCH;
        if (g < 0 && v[idx]) g = idx;
      end
    end else if (int'(s) < NCH && v[s]) begin
      g = int'(s);
    end
  endtask

  // Called at the negedge after the inputs are set. It checks the
  // combinational and registered outputs, then advances the model across
  // one posedge.
  task automatic step();
    int             g;
    logic [NCH-1:0] exp_rdy;
    logic           ld;
    logic [W-1:0]   d;
    #1;
    ld = (sb.size() == 0) || out_ready;
    model_grant(in_valid, mode, sel, m_ptr, g);
    exp_rdy = '0;
    if (rst_n && ld && g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("out_data", 32'(out_data), 32'(sb[0][W-1:0]));
      chk("out_ch", 32'(out_ch), 32'(sb[0][SELW+W-1:W]));
    end
    @(posedge clk);
    if (!rst_n) begin
      sb.delete();
      m_ptr = NCH - 1;
    end else if (ld) begin
      if (sb.size() != 0) void'(sb.pop_front());
      if (g >= 0) begin
        d = in_data[g*W +: W];
        sb.push_back({SELW'(g), d});
        m_ptr = g;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0]    hd;
    logic [SELW-1:0] hc;
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b1;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset held with every channel requesting.
    step();
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    // Round-robin with all channels valid.
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step();
      chk("rr_seq_data", 32'(out_data), 32'(rr_tbl[j]));
      chk("rr_seq_ch", 32'(out_ch), 32'(rr_ch[j]));
    end

    // Backpressure holds the beat.
    out_ready = 1'b0;
    hd = out_data;
    hc = out_ch;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("bp_data", 32'(out_data), 32'(hd));
      chk("bp_ch", 32'(out_ch), 32'(hc));
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();

    // Fixed select on channel 2.
    mode = 1'b1;
    sel  = 2'd2;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("fix_ch", 32'(out_ch), 32'd2);
      chk("fix_data", 32'(out_data), 32'h33);
    end
    in_valid = 4'b1011;
    step();
    step();
    chk("fix_drain", 32'(out_valid), 32'd0);

    // Park the pointer on channel 1, then run the sparse round-robin pattern.
    sel      = 2'd1;
    in_valid = 4'b0010;
    step();
    mode     = 1'b0;
    in_valid = 4'b1010;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("sparse_ch", 32'(out_ch), 32'(sp_ch[j]));
      chk("sparse_rdy02", 32'(in_ready[0] | in_ready[2]), 32'd0);
    end

    // Reset while a beat is held under backpressure.
    out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    rst_n     = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    step();
    chk("midrst_first_ch", 32'(out_ch), 32'd0);

    // Randomised traffic checked against the model.
    for (int j = 0; j < 300; j++) begin
      in_valid  = NCH'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      mode      = ($urandom_range(0, 3) == 0);
      sel       = SELW'($urandom_range(0, 3));
      in_data   = {$urandom(), 32'd0} >> 32;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
